// File: rtl/wordle_pkg.sv
// Shared constants, colour codes and scorer state type for the Wordle scorer.
// Duplicate-letter handling is selected elsewhere by WORDLE_DUP_CHECK_EN.
package wordle_pkg;

    localparam int LETTERS  = 5;
    localparam int LETTER_W = 8;
    localparam int WORD_W   = LETTERS * LETTER_W;
    localparam int SCORE_W  = 2 * LETTERS;
    localparam int IDX_W    = 3;

    localparam logic [1:0] GRAY   = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    localparam logic [SCORE_W-1:0] ALL_GREEN = {LETTERS{GREEN}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YELLOW,
        ST_DONE
    } state_t;

endpackage

// File: rtl/wordle_letter_match.sv
// Combinational search for the lowest answer slot holding a letter that is not yet used.
// Letter 0 sits in the most significant byte of the answer word.
module wordle_letter_match
    import wordle_pkg::*;
(
    input  logic [LETTER_W-1:0] letter_i,
    input  logic [WORD_W-1:0]   answer_i,
    input  logic [LETTERS-1:0]  used_i,
    output logic                found_o,
    output logic [IDX_W-1:0]    j_o
);

    // Scanning from the top down lets the lowest matching slot win.
    always_comb begin
        found_o = 1'b0;
        j_o     = '0;
        for (int k = LETTERS - 1; k >= 0; k--) begin
            if (!used_i[k] && (answer_i[WORD_W-1-LETTER_W*k -: LETTER_W] == letter_i)) begin
                found_o = 1'b1;
                j_o     = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/wordle_scorer.sv
// Wordle guess scorer: one green pass, then five yellow passes, result held until taken.
// Define WORDLE_DUP_CHECK_EN to consume answer letters so duplicates are not over-counted.
module wordle_scorer
    import wordle_pkg::*;
(
    input  logic        Clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [39:0] guess,
    input  logic [39:0] answer,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  score,
    output logic        win
);

    state_t               state_q, state_d;
    logic [WORD_W-1:0]    guess_q, guess_d;
    logic [WORD_W-1:0]    answer_q, answer_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LETTERS-1:0]   used_q, used_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic [LETTER_W-1:0]  cur_letter;
    logic                 cur_green;
    logic [LETTERS-1:0]   match_mask;
    logic                 match_found;
    logic [IDX_W-1:0]     match_j;

    always_comb begin
        cur_letter = '0;
        cur_green  = 1'b0;
        for (int i = 0; i < LETTERS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_letter = guess_q[WORD_W-1-LETTER_W*i -: LETTER_W];
                cur_green  = (score_q[SCORE_W-1-2*i -: 2] == GREEN);
            end
        end
    end

`ifdef WORDLE_DUP_CHECK_EN
    assign match_mask = used_q;
`else
    assign match_mask = '0;
`endif

    wordle_letter_match u_match (
        .letter_i (cur_letter),
        .answer_i (answer_q),
        .used_i   (match_mask),
        .found_o  (match_found),
        .j_o      (match_j)
    );

    always_comb begin
        // NOTE: every next-state signal defaults to its register so no path infers a latch.
        state_d  = state_q;
        guess_d  = guess_q;
        answer_d = answer_q;
        score_d  = score_q;
        used_d   = used_q;
        idx_d    = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    guess_d  = guess;
                    answer_d = answer;
                    state_d  = ST_GREEN;
                end
            end
            ST_GREEN: begin
                for (int i = 0; i < LETTERS; i++) begin
                    if (guess_q[WORD_W-1-LETTER_W*i -: LETTER_W] ==
                        answer_q[WORD_W-1-LETTER_W*i -: LETTER_W]) begin
                        score_d[SCORE_W-1-2*i -: 2] = GREEN;
                        used_d[i]                   = 1'b1;
                    end else begin
                        score_d[SCORE_W-1-2*i -: 2] = GRAY;
                        used_d[i]                   = 1'b0;
                    end
                end
                idx_d   = '0;
                state_d = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (!cur_green && match_found) begin
                    for (int i = 0; i < LETTERS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            score_d[SCORE_W-1-2*i -: 2] = YELLOW;
                        end
                        if (match_j == IDX_W'(i)) begin
                            used_d[i] = 1'b1;
                        end
                    end
                end
                if (idx_q == IDX_W'(LETTERS - 1)) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            guess_q  <= '0;
            answer_q <= '0;
            score_q  <= '0;
            used_q   <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            answer_q <= answer_d;
            score_q  <= score_d;
            used_q   <= used_d;
            idx_q    <= idx_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign score     = score_q;
    assign win       = (score_q == ALL_GREEN);

endmodule

// File: doc/wordle_scorer.md
WORDLE_SCORER -- requirements
Module: wordle_scorer

Interface
REQ-001 The block SHALL use reset, asynchronous, active-high, and clock Clk.
REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk  in  1  clock
- reset  in  1  async active-high reset
- in_valid  in  1  guess/answer pair offered
- in_ready  out  1  scorer idle, pair accepted on in_valid&in_ready
- guess  in  40  five ASCII bytes; letter 0 in [39:32]
- answer  in  40  five ASCII bytes, same ordering
- out_valid  out  1  score available
- out_ready  in  1  consumer takes score on out_valid&out_ready
- score  out  10  2 bits per letter; letter 0 in [9:8]
- win  out  1  all five letters green

Function
REQ-003 Colour codes SHALL be 2'b00 gray, 2'b01 yellow, 2'b10 green; 2'b11 is never produced.
REQ-004 FSM states SHALL be IDLE, GREEN, YELLOW, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-005 IDLE: on in_valid&in_ready, guess and answer SHALL be latched, and the state SHALL go to GREEN; inputs are ignored in all other states.
REQ-006 GREEN (1 cycle): each position i with guess[i]==answer[i] SHALL be marked green and answer slot i marked used; the remaining positions are cleared to gray and the other used bits are cleared; then go to YELLOW with index i=0.
REQ-007 YELLOW (5 cycles, i=0..4): if position i is not green, the scorer SHALL search for the lowest j with answer[j]==guess[i] and used[j]==0; if one is found, position i is marked yellow and used[j] is set; at i=4 go to DONE.
REQ-008 Latency SHALL be exactly 6 cycles: out_valid rises on the 6th rising edge after the accepting edge.
REQ-009 DONE: score and win SHALL be held stable while out_ready=0; on out_ready=1 go to IDLE, and out_valid falls next cycle.
REQ-010 win SHALL equal (score==10'b10_10_10_10_10) and is meaningful only while out_valid=1.
REQ-011 Bytes SHALL be compared as raw 8-bit values; there is no case folding and no alphabet check.
REQ-012 in_valid and out_ready SHALL have no effect outside IDLE and DONE respectively, so a back-to-back offer waits for in_ready.

Reset
REQ-013 On reset, the state SHALL go to IDLE; in_ready=1, out_valid=0, score=0, win=0, and the used mask, index and latched words are cleared.
REQ-014 Reset asserted mid-operation (GREEN/YELLOW/DONE) SHALL abort the score without emitting out_valid.

Configuration
REQ-015 Macro WORDLE_DUP_CHECK_EN SHALL select the duplicate-letter handling.
- Defined: the used-mask rule of REQ-006/REQ-007 applies.
- Undefined: the used mask is ignored, and a non-green position is yellow if its letter appears anywhere in answer.
- Latency and interface are identical in both builds.

Structure
REQ-016 Shared package wordle_pkg SHALL hold: LETTERS=5, LETTER_W=8, WORD_W=40, colour constants GRAY/YELLOW/GREEN, and the scorer state typedef.
REQ-017 A sub-module wordle_letter_match SHALL be used. It is purely combinational: a letter, the answer and the used mask go in; found and a 3-bit lowest-index j come out. It is instantiated once in wordle_scorer.

Verification
REQ-018 answer="ROBOT", guess="ROBOT" -> score=10_10_10_10_10, win=1, out_valid on cycle 6.
REQ-019 answer="ROBOT", guess="ROBIN" -> score=10_10_10_00_00, win=0.
REQ-020 answer="ROBOT", guess="OOOZZ" -> with WORDLE_DUP_CHECK_EN, score=01_10_00_00_00; without it, score=01_10_01_00_00.
REQ-021 Backpressure: out_ready=0 for 10 cycles in DONE -> score/win stable, in_ready=0, a new in_valid is not accepted; out_ready=1 -> IDLE next cycle.
REQ-022 Reset pulse during YELLOW (i=2) -> next cycle in_ready=1, out_valid=0, score=0; a following pair "ABBOT"/"BABBY" scores 01_01_10_00_00 (with WORDLE_DUP_CHECK_EN).
